// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
//   Operand-forwarding select and load-use interlock for the RV pipeline.
//
//   Forwarding: for each EX source operand, pick the youngest post-EX stage
//   (lowest index) that writes a matching non-zero register. Select 0 means
//   the register file / ID-EX value, k means stage k-1.
//
//   Interlock: a load in EX whose destination is read by the instruction in
//   ID stalls PC and IF/ID and bubbles ID/EX for LOAD_STAGE non-held cycles.
//   Stall cycles are counted in a saturating performance counter.
//
// Ports
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_ex_rs           EX source addresses, source j at [j*REG_AW +: REG_AW]
//   i_stg_rd/i_stg_we destination / write enable of each post-EX stage
//   i_id_rs           ID source addresses
//   i_id_rs_used      ID source j is actually read
//   i_ex_rd/i_ex_we   EX destination / write enable
//   i_ex_is_load      EX instruction is a load
//   i_hold            global pipeline freeze
//   i_flush           flush of ID and EX
//   o_fwd_sel         per-source forward select, SEL_W bits each
//   o_stall           freeze PC and IF/ID
//   o_bubble          insert NOP into ID/EX (same as o_stall)
//   o_stall_cycles    saturating stall-cycle counter
//
//   PERF_W sets the internal width of the performance counter (32 in
//   production; a narrower value makes saturation reachable in simulation).
//   The output is zero-extended to 32 bits.
// ---------------------------------------------------------------------------
module fwd_hazard_unit #(
   parameter int NUM_SRC    = 2,
   parameter int NUM_STAGES = 2,
   parameter int REG_AW     = 5,
   parameter int LOAD_STAGE = 1,
   parameter int PERF_W     = 32,
   localparam int SEL_W     = $clog2(NUM_STAGES + 1)
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic [NUM_SRC*REG_AW-1:0]    i_ex_rs,
   input  logic [NUM_STAGES*REG_AW-1:0] i_stg_rd,
   input  logic [NUM_STAGES-1:0]        i_stg_we,
   input  logic [NUM_SRC*REG_AW-1:0]    i_id_rs,
   input  logic [NUM_SRC-1:0]           i_id_rs_used,
   input  logic [REG_AW-1:0]            i_ex_rd,
   input  logic                         i_ex_we,
   input  logic                         i_ex_is_load,
   input  logic                         i_hold,
   input  logic                         i_flush,
   output logic [NUM_SRC*SEL_W-1:0]     o_fwd_sel,
   output logic                         o_stall,
   output logic                         o_bubble,
   output logic [31:0]                  o_stall_cycles
);

   // Count loaded on detection: the detect cycle itself is the first stall
   // cycle, so LOAD_STAGE-1 further cycles remain.
   localparam logic [SEL_W-1:0] RELOAD =
      (LOAD_STAGE > 0) ? SEL_W'(LOAD_STAGE - 1) : '0;

   typedef enum logic {IDLE, STALL} state_t;

   // ------------------------------------------------------------------
   // Forwarding select per source
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
         logic [SEL_W-1:0] sel;
         always_comb begin
            sel = '0;
            // Walk from the oldest stage to the youngest so the lowest
            // matching index is the last assignment and therefore wins.
            for (int k = NUM_STAGES - 1; k >= 0; k--) begin
               if (i_stg_we[k] &&
                   (i_stg_rd[k*REG_AW +: REG_AW] != '0) &&
                   (i_stg_rd[k*REG_AW +: REG_AW] == i_ex_rs[gi*REG_AW +: REG_AW]))
                  sel = SEL_W'(k + 1);
            end
         end
         assign o_fwd_sel[gi*SEL_W +: SEL_W] = sel;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Load-use detect
   // ------------------------------------------------------------------
   logic [NUM_SRC-1:0] src_hit;
   logic               det;

   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_det
         assign src_hit[gi] = i_id_rs_used[gi] &&
                              (i_id_rs[gi*REG_AW +: REG_AW] == i_ex_rd);
      end
   endgenerate

   assign det = (LOAD_STAGE != 0) && i_ex_we && i_ex_is_load &&
                (i_ex_rd != '0) && (|src_hit);

   // ------------------------------------------------------------------
   // Stall counter: IDLE when the count is zero, STALL otherwise
   // ------------------------------------------------------------------
   logic [SEL_W-1:0] cnt_reg;
   logic [SEL_W-1:0] cnt_next;
   state_t           state;

   assign state = (cnt_reg != '0) ? STALL : IDLE;

   always_ff @(posedge i_clk) begin
      if (i_rst)
         cnt_reg <= '0;
      else
         cnt_reg <= cnt_next;
   end

   always_comb begin
      cnt_next = cnt_reg;
      o_stall  = 1'b0;
      case (state)
         IDLE: begin
            o_stall = !i_flush && det;
            if (i_flush)
               cnt_next = '0;
            else if (!i_hold && det)
               cnt_next = RELOAD;
         end
         STALL: begin
            // A new detect here cannot reload: EX holds a bubble.
            o_stall = !i_flush;
            if (i_flush)
               cnt_next = '0;
            else if (!i_hold)
               cnt_next = cnt_reg - 1'b1;
         end
         default: begin
            cnt_next = '0;
            o_stall  = 1'b0;
         end
      endcase
   end

   assign o_bubble = o_stall;

   // ------------------------------------------------------------------
   // Saturating stall-cycle counter; held cycles are not counted
   // ------------------------------------------------------------------
   logic [PERF_W-1:0] perf_reg;

   always_ff @(posedge i_clk) begin
      if (i_rst)
         perf_reg <= '0;
      else if (o_stall && !i_hold && (perf_reg != '1))
         perf_reg <= perf_reg + 1'b1;
   end

   assign o_stall_cycles = 32'(perf_reg);

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised operand-forwarding and load-use interlock unit for the RV pipeline.
- Selects, per EX source operand, the youngest in-flight producer among NUM_STAGES post-EX stages, or the register file when there is no match.
- Detects load-use hazards between ID and EX and holds a multi-cycle stall, sized by load-data latency, through a counter.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- NUM_SRC, 2: source operands per instruction.
- NUM_STAGES, 2: forwarding stages after EX; index 0 = MEM (youngest), 1 = WB, and so on.
- REG_AW, 5: register address width.
- LOAD_STAGE, 1: stage index where load data first becomes forwardable. Legal range 0..NUM_STAGES-1; 0 means no load-use stall.
- SEL_W, derived localparam = $clog2(NUM_STAGES+1): width of each forward select.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_ex_rs  in  NUM_SRC*REG_AW  EX source addresses; source j at bits [j*REG_AW +: REG_AW]
- i_stg_rd  in  NUM_STAGES*REG_AW  destination address of each post-EX stage
- i_stg_we  in  NUM_STAGES  register write enable of each post-EX stage
- i_id_rs  in  NUM_SRC*REG_AW  ID source addresses
- i_id_rs_used  in  NUM_SRC  ID source actually read by the instruction
- i_ex_rd  in  REG_AW  EX destination
- i_ex_we  in  1  EX writes a register
- i_ex_is_load  in  1  EX instruction is a load
- i_hold  in  1  global pipeline freeze (e.g. memory wait)
- i_flush  in  1  branch/exception flush of ID and EX
- o_fwd_sel  out  NUM_SRC*SEL_W  per source: 0 = register file/ID-EX value, k = stage k-1
- o_stall  out  1  freeze PC and IF/ID
- o_bubble  out  1  insert NOP into ID/EX; equal to o_stall
- o_stall_cycles  out  32  stall-cycle performance counter

Behaviour:
- Forwarding (combinational):
  - For source j, o_fwd_sel[j] = k+1 for the lowest k with i_stg_we[k], i_stg_rd[k] != 0 and i_stg_rd[k] == rs[j]. Otherwise 0.
  - Youngest producer always wins.
  - Address 0 never forwards.
  - Forwarding is independent of i_hold, i_flush and the stall state.
- Hazard detect (combinational): det = LOAD_STAGE != 0 && i_ex_we && i_ex_is_load && i_ex_rd != 0 && any j with i_id_rs_used[j] and i_id_rs[j] == i_ex_rd.
- Stall counter:
  - cnt is $clog2(NUM_STAGES+1) bits, reset 0. Two states: IDLE (cnt == 0) and STALL (cnt != 0).
  - o_stall = !i_flush && (det || cnt != 0).
  - Update priority, first match wins:
    - i_rst: cnt <= 0.
    - i_flush: cnt <= 0.
    - i_hold: cnt unchanged.
    - cnt == 0 && det: cnt <= LOAD_STAGE-1.
    - cnt != 0: cnt <= cnt-1.
  - Result: a load-use stalls for exactly LOAD_STAGE non-held cycles, so the consumer reaches EX when the load sits in stage LOAD_STAGE and o_fwd_sel selects it.
  - Held cycles extend the stall without consuming count.
- Flush: in the flush cycle o_stall = 0 and o_bubble = 0, and any pending stall is cancelled.
- o_stall_cycles:
  - Reset 0.
  - Increments by 1 on each cycle with o_stall && !i_hold.
  - Saturates at 32'hFFFF_FFFF.
  - Unaffected by flush.
- Reset values: cnt = 0, o_stall_cycles = 0. While in reset, o_stall follows det; the pipeline is held in reset anyway.
- Boundaries:
  - Same rd in several stages: the lowest index wins.
  - Both ID sources matching the load: a single stall sequence.
  - A source with i_id_rs_used = 0 never stalls.
  - det during STALL is ignored for reload; EX holds a bubble, so det is 0 there by construction.

Test Plan:
1. Defaults; i_stg_we = 2'b11, i_stg_rd = {5'd3, 5'd3}, i_ex_rs = {5'd3, 5'd3} -> o_fwd_sel = {2'd1, 2'd1} (MEM beats WB). Change i_stg_rd[0] to 4 -> selects 2.
2. i_stg_rd = {5'd0, 5'd0} with we set, i_ex_rs = 0 -> o_fwd_sel = 0. Write-enable low on a matching stage -> 0.
3. Load x5 in EX, ID rs1 = 5 used -> o_stall = o_bubble = 1 for exactly 1 cycle. Next cycle: load's rd in stage 0 (MEM), EX has a bubble -> o_stall = 0. Following cycle: consumer in EX with the load in WB -> o_fwd_sel[0] = 2. o_stall_cycles = 1.
4. LOAD_STAGE = 2, NUM_STAGES = 3: load-use -> 2 stall cycles. Assert i_hold in the second stall cycle -> 3 stall cycles total; o_stall_cycles = 2.
5. LOAD_STAGE = 2 load-use, i_flush in the second stall cycle -> o_stall = 0 that cycle and after. A new load-use afterwards -> a fresh 2-cycle stall.
6. Same load-use, but i_id_rs_used = 0, or i_ex_rd = 0, or i_ex_is_load = 0 -> no stall. Force o_stall_cycles to the saturation value via a long hold-free stall loop in a short-counter sim build -> stays at all-ones.
